// File: rtl/bip_arb_pkg.sv
// Shared types and constants for the BIP data-memory arbiter.
// Stats counters are built only when BIP_ARB_STATS_EN is defined.
package bip_arb_pkg;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_DBG = 1'b1
  } owner_t;

  localparam int MAX_LOCK_DEF = 8;
  localparam int STAT_W       = 16;

  function automatic logic [STAT_W-1:0] sat_inc(
    input logic [STAT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/bip_rr_pick.sv
// Two-way grant selector: lone request wins, else lock, else round-robin.
// Purely combinational; en=0 suppresses every grant.
import bip_arb_pkg::*;

module bip_rr_pick #(
  parameter int max_lock = MAX_LOCK_DEF,
  parameter int len_lock = 4
) (
  input  logic                en,
  input  logic                cpu_req,
  input  logic                dbg_req,
  input  logic                locked,
  input  logic [len_lock-1:0] lock_cnt,
  input  owner_t              last_owner,
  output logic                cpu_gnt,
  output logic                dbg_gnt
);

  logic lock_win;
  logic both;

  always_comb begin
    cpu_gnt  = 1'b0;
    dbg_gnt  = 1'b0;
    both     = cpu_req && dbg_req;
    lock_win = locked && (lock_cnt < len_lock'(max_lock));
    if (en) begin
      unique case (1'b1)
        (cpu_req && !dbg_req): cpu_gnt = 1'b1;
        (dbg_req && !cpu_req): dbg_gnt = 1'b1;
        (both && lock_win):    dbg_gnt = 1'b1;
        (both && !lock_win): begin
          if (last_owner == OWNER_CPU) dbg_gnt = 1'b1;
          else                         cpu_gnt = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/bip_mem_arbiter.sv
// CPU/debug arbiter for the single-port BIP data memory.
// Optional stats counters: define BIP_ARB_STATS_EN.
import bip_arb_pkg::*;

module bip_mem_arbiter #(
  parameter int len_addr = 11,
  parameter int len_data = 16,
  parameter int max_lock = MAX_LOCK_DEF,
  parameter int len_lock = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cpu_req,
  input  logic                cpu_wr,
  input  logic [len_addr-1:0] cpu_addr,
  input  logic [len_data-1:0] cpu_wdata,
  output logic                cpu_gnt,
  output logic                cpu_rvalid,
  output logic [len_data-1:0] cpu_rdata,
  input  logic                dbg_req,
  input  logic                dbg_wr,
  input  logic                dbg_lock,
  input  logic [len_addr-1:0] dbg_addr,
  input  logic [len_data-1:0] dbg_wdata,
  output logic                dbg_gnt,
  output logic                dbg_rvalid,
  output logic [len_data-1:0] dbg_rdata,
  output logic                Rd,
  output logic                Wr,
  output logic [len_addr-1:0] Addr,
  output logic [len_data-1:0] In_Data,
  input  logic [len_data-1:0] Out_Data,
  output logic [STAT_W-1:0]   conflict_cnt,
  output logic [STAT_W-1:0]   cpu_stall_cnt
);

  owner_t              last_owner_q, last_owner_d;
  logic                locked_q, locked_d;
  logic [len_lock-1:0] lock_cnt_q, lock_cnt_d;
  logic                cpu_rv_q, cpu_rv_d;
  logic                dbg_rv_q, dbg_rv_d;
  logic [len_addr-1:0] addr_q, addr_d;
  logic [len_data-1:0] wdata_q, wdata_d;

  bip_rr_pick #(
    .max_lock (max_lock),
    .len_lock (len_lock)
  ) u_pick (
    .en         (reset),
    .cpu_req    (cpu_req),
    .dbg_req    (dbg_req),
    .locked     (locked_q),
    .lock_cnt   (lock_cnt_q),
    .last_owner (last_owner_q),
    .cpu_gnt    (cpu_gnt),
    .dbg_gnt    (dbg_gnt)
  );

  always_comb begin
    Rd      = 1'b0;
    Wr      = 1'b0;
    Addr    = addr_q;
    In_Data = wdata_q;
    if (cpu_gnt) begin
      Rd      = ~cpu_wr;
      Wr      = cpu_wr;
      Addr    = cpu_addr;
      In_Data = cpu_wdata;
    end else if (dbg_gnt) begin
      Rd      = ~dbg_wr;
      Wr      = dbg_wr;
      Addr    = dbg_addr;
      In_Data = dbg_wdata;
    end
    addr_d  = Addr;
    wdata_d = In_Data;

    last_owner_d = last_owner_q;
    if (cpu_gnt) last_owner_d = OWNER_CPU;
    if (dbg_gnt) last_owner_d = OWNER_DBG;

    locked_d = locked_q;
    if (dbg_gnt && dbg_lock) locked_d = 1'b1;
    else if (!dbg_lock)      locked_d = 1'b0;

    // CPU grant ends one lock window; the lock itself persists
    lock_cnt_d = lock_cnt_q;
    if (!dbg_lock || cpu_gnt)
      lock_cnt_d = '0;
    else if (dbg_gnt && cpu_req &&
             lock_cnt_q < len_lock'(max_lock))
      lock_cnt_d = lock_cnt_q + 1'b1;

    cpu_rv_d = cpu_gnt & ~cpu_wr;
    dbg_rv_d = dbg_gnt & ~dbg_wr;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_owner_q <= OWNER_DBG;
      locked_q     <= 1'b0;
      lock_cnt_q   <= '0;
      cpu_rv_q     <= 1'b0;
      dbg_rv_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      last_owner_q <= last_owner_d;
      locked_q     <= locked_d;
      lock_cnt_q   <= lock_cnt_d;
      cpu_rv_q     <= cpu_rv_d;
      dbg_rv_q     <= dbg_rv_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  // Masked so a read granted just before reset never reports
  assign cpu_rvalid = cpu_rv_q & reset;
  assign dbg_rvalid = dbg_rv_q & reset;
  assign cpu_rdata  = Out_Data;
  assign dbg_rdata  = Out_Data;

`ifdef BIP_ARB_STATS_EN
  logic [STAT_W-1:0] conf_q, conf_d;
  logic [STAT_W-1:0] stall_q, stall_d;

  always_comb begin
    conf_d  = conf_q;
    stall_d = stall_q;
    if (cpu_req && dbg_req) conf_d  = sat_inc(conf_q);
    if (cpu_req && !cpu_gnt) stall_d = sat_inc(stall_q);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      conf_q  <= '0;
      stall_q <= '0;
    end else begin
      conf_q  <= conf_d;
      stall_q <= stall_d;
    end
  end

  assign conflict_cnt  = conf_q;
  assign cpu_stall_cnt = stall_q;
`else
  assign conflict_cnt  = '0;
  assign cpu_stall_cnt = '0;
`endif

endmodule
